// File: rtl/spi_count_pkg.sv
// Shared opcodes, FSM states and the command arithmetic for the SPI-controlled counter.
package spi_count_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam byte_t OP_NOP   = 8'h00;
    localparam byte_t OP_INC   = 8'h01;
    localparam byte_t OP_DEC   = 8'h02;
    localparam byte_t OP_LOAD  = 8'h03;
    localparam byte_t OP_CLEAR = 8'h04;
    localparam byte_t OP_RUN   = 8'h05;
    localparam byte_t OP_STOP  = 8'h06;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        OPERAND
    } state_t;

    // Single-byte commands only; LOAD/RUN/STOP leave the value alone here and
    // are handled by the FSM itself.
    function automatic byte_t apply_op(input byte_t op, input byte_t cur);
        byte_t res;
        res = cur;
        case (op)
            OP_INC:   res = cur + 8'd1;
            OP_DEC:   res = cur - 8'd1;
            OP_CLEAR: res = '0;
            default:  res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_count_sync.sv
// Synchronizer chain plus registered rise/fall detect for one asynchronous input.
module spi_count_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the chain into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    // Level is taken from the edge-detect flop so it lines up with the pulses.
    assign level = prev;

endmodule

// File: rtl/spi_count_ctrl.sv
// SPI mode-0 command slave driving an 8-bit wrapping counter, all in the clk domain.
// Optional auto-increment prescaler and run flag: define SPI_COUNT_AUTO_INC_EN.
module spi_count_ctrl
    import spi_count_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       CE0,
    output logic       MISO,
    output logic [7:0] count,
    output logic [3:0] led,
    output logic       frame_err
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ce_lvl, ce_rise, ce_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_count_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // CE0 idles high, so its chain resets high to avoid a spurious frame start.
    spi_count_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_ce (
        .clk(clk), .rst(rst), .din(CE0),
        .level(ce_lvl), .rise(ce_rise), .fall(ce_fall)
    );

    spi_count_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sync = ^{sclk_lvl, ce_lvl, mosi_rise, mosi_fall};

    state_t      state;
    logic [2:0]  bit_cnt;
    byte_t       rx_shift;
    byte_t       tx_shift;
    byte_t       rx_byte;
    byte_t       cmd_count;
    logic        byte_done;

    assign rx_byte   = {rx_shift[BYTE_W-2:0], mosi_s};
    assign byte_done = (state != IDLE) && !ce_rise && sclk_rise && (bit_cnt == 3'd7);
    assign cmd_count = (state == OPERAND) ? rx_byte : apply_op(rx_byte, count);

`ifdef SPI_COUNT_AUTO_INC_EN
    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               run;

    assign tick = (presc == PRESC_W'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end
`else
    localparam int UNUSED_PRESCALE = PRESCALE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            count     <= '0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
`ifdef SPI_COUNT_AUTO_INC_EN
            run       <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef SPI_COUNT_AUTO_INC_EN
            // A tick landing on a command cycle is dropped; the command's update wins.
            if (tick && run && !byte_done) begin
                count <= count + 8'd1;
            end
`endif
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ce_fall) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        MISO     <= count[BYTE_W-1];
                        tx_shift <= {count[BYTE_W-2:0], 1'b0};
                    end
                end
                default: begin
                    if (ce_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        MISO    <= 1'b0;
                        if (bit_cnt != 3'd0 || state == OPERAND) begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        // Full byte reload: the following SCLK fall presents its MSB.
                        if (byte_done) begin
                            count    <= cmd_count;
                            tx_shift <= cmd_count;
                            state    <= (state == CMD && rx_byte == OP_LOAD) ? OPERAND : CMD;
`ifdef SPI_COUNT_AUTO_INC_EN
                            if (state == CMD && rx_byte == OP_RUN)  run <= 1'b1;
                            if (state == CMD && rx_byte == OP_STOP) run <= 1'b0;
`endif
                        end
                        if (sclk_fall) begin
                            MISO     <= tx_shift[BYTE_W-1];
                            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    assign led = count[3:0];

endmodule

// File: tb/tb_spi_count_ctrl.sv
// Self-checking bench for spi_count_ctrl: SPI master tasks and a byte-level reference model.
module tb_spi_count_ctrl;

    localparam int SYNC  = 2;
    localparam int PRESC = 10;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       SCLK;
    logic       MOSI;
    logic       CE0;
    logic       MISO;
    logic [7:0] count;
    logic [3:0] led;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_pulses = 0;

    logic [7:0] fb[16];
    logic [7:0] got[16];
    logic [7:0] exp_miso[16];
    logic [7:0] m_count;
    bit         exp_err;
    bit         m_run;

    spi_count_ctrl #(.SYNC_STAGES(SYNC), .PRESCALE(PRESC)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .CE0(CE0),
        .MISO(MISO), .count(count), .led(led), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_err === 1'b1) err_pulses <= err_pulses + 1;

    // Shift nbits of b MSB first; align >= 0 holds the last rise until its command
    // cycle falls on that residue of the cycle counter.
    task automatic shift_bits(input logic [7:0] b, input int nbits, input int align,
                              output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            MOSI = b[i];
            repeat (HALF) @(negedge clk);
            if (align >= 0 && i == 0)
                while (((cyc + SYNC + 2) % PRESC) != align) @(negedge clk);
            SCLK  = 1'b1;
            rx[i] = MISO;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input int n, input int last_bits, input int align);
        logic [7:0] r;
        CE0 = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            shift_bits(fb[k], (k == n - 1) ? last_bits : 8, (k == n - 1) ? align : -1, r);
            got[k] = r;
        end
        repeat (HALF) @(negedge clk);
        CE0  = 1'b1;
        MOSI = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Byte-level reference: MISO carries the count as it stood before each byte.
    function automatic void model_frame(input int n, input int last_bits);
        bit want_operand;
        int done;
        want_operand = 0;
        done = (last_bits == 8) ? n : n - 1;
        for (int k = 0; k < done; k++) begin
            exp_miso[k] = m_count;
            if (want_operand) begin
                m_count = fb[k];
                want_operand = 0;
            end else begin
                case (fb[k])
                    8'h01: m_count = m_count + 8'd1;
                    8'h02: m_count = m_count - 8'd1;
                    8'h03: want_operand = 1;
                    8'h04: m_count = 8'h00;
`ifdef SPI_COUNT_AUTO_INC_EN
                    8'h05: m_run = 1;
                    8'h06: m_run = 0;
`endif
                    default: ;
                endcase
            end
        end
        exp_err = (done != n) || want_operand;
    endfunction

    function automatic logic [7:0] rand_op();
        logic [7:0] b;
        case ($urandom_range(0, 6))
            0:       b = 8'h00;
            1, 2:    b = 8'h01;
            3:       b = 8'h02;
            4:       b = 8'h03;
            5:       b = 8'h04;
            default: b = 8'($urandom);
        endcase
`ifdef SPI_COUNT_AUTO_INC_EN
        if (b == 8'h05 || b == 8'h06) b = 8'h00;
`endif
        return b;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL reset_count: got %h expected 00", count); end
        total++; if (led !== 4'h0) begin bad++; $display("FAIL reset_led: got %h expected 0", led); end
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (count !== 8'h00 || MISO !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: count %h miso %b expected 00/0", count, MISO);
        end
    endtask

    task automatic test_inc3();
        int e0;
        e0 = err_pulses;
        fb[0] = 8'h01; fb[1] = 8'h01; fb[2] = 8'h01;
        send_frame(3, 8, -1);
        model_frame(3, 8);
        total++; if (count !== 8'h03) begin bad++; $display("FAIL inc3_count: got %h expected 03", count); end
        total++; if (led !== 4'h3) begin bad++; $display("FAIL inc3_led: got %h expected 3", led); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got[k] !== 8'(k)) begin bad++; $display("FAIL inc3_miso%0d: got %h expected %h", k, got[k], 8'(k)); end
        end
        total++; if (err_pulses - e0 !== 0) begin bad++; $display("FAIL inc3_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_load_wrap();
        fb[0] = 8'h03; fb[1] = 8'hFF;
        send_frame(2, 8, -1); model_frame(2, 8);
        total++; if (count !== 8'hFF) begin bad++; $display("FAIL load_ff: got %h expected ff", count); end
        total++; if (got[1] !== 8'h03) begin bad++; $display("FAIL load_miso_operand: got %h expected 03", got[1]); end
        fb[0] = 8'h01;
        send_frame(1, 8, -1); model_frame(1, 8);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL inc_wrap: got %h expected 00", count); end
        fb[0] = 8'h02;
        send_frame(1, 8, -1); model_frame(1, 8);
        total++; if (count !== 8'hFF) begin bad++; $display("FAIL dec_wrap: got %h expected ff", count); end
        total++; if (led !== 4'hF) begin bad++; $display("FAIL dec_wrap_led: got %h expected f", led); end
    endtask

    task automatic test_abort();
        int e0;
        e0 = err_pulses;
        fb[0] = 8'h03;
        send_frame(1, 8, -1); model_frame(1, 8);
        total++; if (count !== 8'hFF) begin bad++; $display("FAIL abort_load_count: got %h expected ff", count); end
        total++; if (err_pulses - e0 !== 1) begin bad++; $display("FAIL abort_load_err: got %0d pulses expected 1", err_pulses - e0); end
        e0 = err_pulses;
        fb[0] = 8'h01; fb[1] = 8'h01;
        send_frame(2, 5, -1); model_frame(2, 5);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL abort_bit5_count: got %h expected 00", count); end
        total++; if (err_pulses - e0 !== 1) begin bad++; $display("FAIL abort_bit5_err: got %0d pulses expected 1", err_pulses - e0); end
    endtask

    task automatic test_unknown_op();
        fb[0] = 8'h7E; fb[1] = 8'h01;
        send_frame(2, 8, -1); model_frame(2, 8);
        total++; if (got[1] !== 8'h00) begin bad++; $display("FAIL unknown_unchanged: got %h expected 00", got[1]); end
        total++; if (count !== 8'h01) begin bad++; $display("FAIL unknown_then_inc: got %h expected 01", count); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            int n;
            int lb;
            int e0;
            int done;
            n    = $urandom_range(1, 4);
            lb   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            done = (lb == 8) ? n : n - 1;
            e0   = err_pulses;
            for (int k = 0; k < n; k++) fb[k] = rand_op();
            send_frame(n, lb, -1);
            model_frame(n, lb);
            total++; if (count !== m_count) begin bad++; $display("FAIL rand%0d_count: got %h expected %h", f, count, m_count); end
            total++; if (err_pulses - e0 !== int'(exp_err)) begin
                bad++; $display("FAIL rand%0d_err: got %0d expected %0d", f, err_pulses - e0, exp_err);
            end
            for (int k = 0; k < done; k++) begin
                total++;
                if (got[k] !== exp_miso[k]) begin bad++; $display("FAIL rand%0d_miso%0d: got %h expected %h", f, k, got[k], exp_miso[k]); end
            end
            total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rand%0d_miso_idle: got %b expected 0", f, MISO); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        fb[0] = 8'h03; fb[1] = 8'h42;
        send_frame(2, 8, -1); model_frame(2, 8);
        total++; if (count !== 8'h42) begin bad++; $display("FAIL mid_setup: got %h expected 42", count); end
        CE0 = 1'b0;
        repeat (HALF) @(negedge clk);
        shift_bits(8'h01, 5, -1, r);
        #2 rst = 1'b1;
        #1;
        total++; if (count !== 8'h00) begin bad++; $display("FAIL mid_rst_count: got %h expected 00", count); end
        total++; if (led !== 4'h0) begin bad++; $display("FAIL mid_rst_led: got %h expected 0", led); end
        total++; if (MISO !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL mid_rst_outs: miso %b err %b expected 0/0", MISO, frame_err);
        end
        CE0 = 1'b1; MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        m_count = 8'h00; m_run = 0;
        fb[0] = 8'h01;
        send_frame(1, 8, -1); model_frame(1, 8);
        total++; if (count !== 8'h01) begin bad++; $display("FAIL mid_after: got %h expected 01", count); end
    endtask

`ifdef SPI_COUNT_AUTO_INC_EN
    task automatic test_auto_run();
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] d;
        fb[0] = 8'h03; fb[1] = 8'h10; fb[2] = 8'h05;
        send_frame(3, 8, -1); model_frame(3, 8);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got[k] !== exp_miso[k]) begin bad++; $display("FAIL run_miso%0d: got %h expected %h", k, got[k], exp_miso[k]); end
        end
        c0 = count;
        repeat (50) @(negedge clk);
        c1 = count;
        d = c1 - c0;
        total++; if (d !== 8'd5) begin bad++; $display("FAIL run_rate: got %0d steps in 50 clk expected 5", d); end
    endtask

    task automatic test_auto_stop();
        fb[0] = 8'h06; fb[1] = 8'h03; fb[2] = 8'h00;
        send_frame(3, 8, -1); model_frame(3, 8);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL stop_count: got %h expected 00", count); end
        repeat (60) @(negedge clk);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL stop_hold: got %h expected 00", count); end
    endtask

    task automatic test_auto_coincide();
        logic [7:0] prev;
        bit         found;
        int         tp;
        found = 0;
        tp    = 0;
        fb[0] = 8'h05;
        send_frame(1, 8, -1); model_frame(1, 8);
        prev = count;
        for (int i = 0; i < 4 * PRESC && !found; i++) begin
            @(negedge clk);
            if (count !== prev) begin found = 1; tp = cyc % PRESC; end
            prev = count;
        end
        total++; if (!found) begin bad++; $display("FAIL tick_seen: got none expected a step within %0d clk", 4 * PRESC); end
        for (int j = 0; j < 3; j++) begin
            int a;
            int b;
            int ticks;
            int want;
            logic [7:0] ca;
            logic [7:0] d;
            a  = cyc;
            ca = count;
            fb[0] = 8'h01;
            send_frame(1, 8, (tp + j - 1 + PRESC) % PRESC);
            b = cyc;
            d = count - ca;
            ticks = 0;
            for (int e = a + 1; e <= b; e++) if (e % PRESC == tp) ticks++;
            want = (j == 1) ? ticks : ticks + 1;
            total++;
            if (d !== 8'(want)) begin bad++; $display("FAIL coincide_off%0d: got %0d steps expected %0d", j - 1, d, want); end
        end
        fb[0] = 8'h06; fb[1] = 8'h03; fb[2] = 8'h00;
        send_frame(3, 8, -1); model_frame(3, 8);
        total++; if (count !== 8'h00) begin bad++; $display("FAIL coincide_final: got %h expected 00", count); end
    endtask
`else
    task automatic test_run_is_nop();
        fb[0] = 8'h05; fb[1] = 8'h06; fb[2] = 8'h01;
        send_frame(3, 8, -1); model_frame(3, 8);
        total++; if (count !== m_count) begin bad++; $display("FAIL run_nop: got %h expected %h", count, m_count); end
        repeat (40) @(negedge clk);
        total++; if (count !== m_count) begin bad++; $display("FAIL run_nop_hold: got %h expected %h", count, m_count); end
    endtask
`endif

    initial begin
        rst = 1'b1; CE0 = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        m_count = 8'h00; m_run = 0;
        test_reset();
        test_inc3();
        test_load_wrap();
        test_abort();
        test_unknown_op();
        test_random();
        test_reset_mid();
`ifdef SPI_COUNT_AUTO_INC_EN
        test_auto_run();
        test_auto_stop();
        test_auto_coincide();
`else
        test_run_is_nop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
